// File: rtl/sudoku_board_serializer.sv
// Streams a snapshotted 9x9 BCD Sudoku board as ASCII text: 9 rows of 9 characters, each row
// ended by CR LF, one byte per valid/ready handshake.
module sudoku_board_serializer #(
    parameter int unsigned GRID_SIZE = 9
) (
    input  logic                                  clk_in,
    input  logic                                  reset_n_in,
    input  logic [GRID_SIZE*GRID_SIZE*4-1:0]      board_in,
    input  logic                                  start_in,
    output logic                                  busy_out,
    output logic [7:0]                            data_out,
    output logic                                  valid_out,
    input  logic                                  ready_in,
    output logic                                  done_out
);

    localparam int unsigned BoardBits = GRID_SIZE * GRID_SIZE * 4;
    localparam logic [3:0]  LastIdx   = 4'(GRID_SIZE - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCell = 2'd1;
    localparam logic [1:0] StCr   = 2'd2;
    localparam logic [1:0] StLf   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [3:0]           row_q, row_d;
    logic [3:0]           col_q, col_d;
    logic [BoardBits-1:0] snap_q, snap_d;
    logic                 done_q, done_d;

    logic       xfer;
    logic [6:0] cell_idx;
    logic [8:0] bit_hi;
    logic [3:0] cell_nib;

    // Row-major cell index; cell (0,0) lives in the most significant nibble.
    assign cell_idx = ({3'b000, row_q} * 7'd9) + {3'b000, col_q};
    assign bit_hi   = 9'(BoardBits - 1) - {cell_idx, 2'b00};
    assign cell_nib = snap_q[bit_hi -: 4];

    assign valid_out = (state_q != StIdle);
    assign busy_out  = (state_q != StIdle);
    assign done_out  = done_q;
    assign xfer      = valid_out && ready_in;

    always_comb begin
        data_out = 8'h00;
        case (state_q)
            StCell: begin
                if (cell_nib == 4'd0) begin
                    data_out = 8'h2E;
                end else if (cell_nib <= 4'd9) begin
                    data_out = 8'h30 + {4'h0, cell_nib};
                end else begin
                    data_out = 8'h3F;
                end
            end
            StCr:    data_out = 8'h0D;
            StLf:    data_out = 8'h0A;
            default: data_out = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_in) begin
                    snap_d  = board_in;
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    state_d = StCell;
                end
            end
            StCell: begin
                if (xfer) begin
                    if (col_q < LastIdx) begin
                        col_d = col_q + 4'd1;
                    end else begin
                        col_d   = 4'd0;
                        state_d = StCr;
                    end
                end
            end
            StCr: begin
                if (xfer) begin
                    state_d = StLf;
                end
            end
            StLf: begin
                if (xfer) begin
                    if (row_q < LastIdx) begin
                        row_d   = row_q + 4'd1;
                        state_d = StCell;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q <= StIdle;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            snap_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_sudoku_board_serializer.sv
// Directed bench for sudoku_board_serializer: expected bytes are queued when a start is driven
// and popped as the DUT transfers them.
module tb_sudoku_board_serializer;

    logic         clk_in = 1'b0;
    logic         reset_n_in;
    logic [323:0] board_in;
    logic         start_in;
    logic         busy_out;
    logic [7:0]   data_out;
    logic         valid_out;
    logic         ready_in;
    logic         done_out;

    always #5 clk_in = ~clk_in;

    sudoku_board_serializer #(.GRID_SIZE(9)) dut (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .board_in   (board_in),
        .start_in   (start_in),
        .busy_out   (busy_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .done_out   (done_out)
    );

    logic [7:0] sb[$];
    int n_vec = 0;
    int n_fail = 0;
    int stream_cyc = 0;
    int n_xfer = 0;
    int n_done = 0;
    int done_cyc = 0;
    int total = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rstn = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [323:0] solved;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        if (n == 4'd0) return 8'h2E;
        if (n <= 4'd9) return 8'h30 + {4'h0, n};
        return 8'h3F;
    endfunction

    task automatic push_board(input logic [323:0] b);
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) sb.push_back(to_ascii(b[323 - 4*(9*r + c) -: 4]));
            sb.push_back(8'h0D);
            sb.push_back(8'h0A);
        end
    endtask

    // Sample at the falling edge, where registered outputs are settled.
    task automatic observe();
        @(negedge clk_in);
        stream_cyc++;
        if (prev_valid && !prev_ready && prev_rstn) begin
            check("stall_valid", {31'b0, valid_out}, 32'd1);
            check("stall_data", {24'b0, data_out}, {24'b0, prev_data});
        end
        if (!valid_out) check("idle_data", {24'b0, data_out}, 32'd0);
        if (done_out) begin
            n_done++;
            done_cyc = stream_cyc;
            check("done_valid", {31'b0, valid_out}, 32'd0);
            check("done_busy", {31'b0, busy_out}, 32'd0);
            check("done_all_bytes", sb.size(), 32'd0);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rstn, input logic push);
        ready_in   = r;
        start_in   = s;
        reset_n_in = rstn;
        if (push) begin
            push_board(board_in);
            stream_cyc = 0;
            n_xfer = 0;
        end
        if (valid_out && r && rstn) begin
            if (sb.size() == 0) check("sb_underflow", {24'b0, data_out}, 32'hFFFF_FFFF);
            else check($sformatf("byte%0d", n_xfer), {24'b0, data_out}, {24'b0, sb.pop_front()});
            n_xfer++;
        end
        prev_valid = valid_out;
        prev_ready = r;
        prev_data  = data_out;
        prev_rstn  = rstn;
    endtask

    // Returns in the done cycle without driving, so the caller may issue a new start there.
    task automatic run_until_done(input logic random_ready, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            observe();
            if (done_out) seen = 1'b1;
            else drive(random_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b1, 1'b0);
        end
        check("done_seen", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        string rows[9];
        rows = '{"534678912", "672195348", "198342567", "859761423", "426853791",
                 "713924856", "961537284", "287419635", "345286179"};
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                solved[323 - 4*(9*r + c) -: 4] = 4'(rows[r][c] - 8'h30);

        reset_n_in = 1'b0; start_in = 1'b0; ready_in = 1'b0; board_in = '0;

        // Reset state
        observe(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        observe();
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_busy", {31'b0, busy_out}, 32'd0);
        check("rst_done", {31'b0, done_out}, 32'd0);
        check("rst_data", {24'b0, data_out}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Full board, ready held high
        board_in = solved; n_done = 0;
        observe(); drive(1'b1, 1'b1, 1'b1, 1'b1);
        observe();
        check("first_busy", {31'b0, busy_out}, 32'd1);
        check("first_valid", {31'b0, valid_out}, 32'd1);
        check("first_data", {24'b0, data_out}, 32'h35);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        run_until_done(1'b0, 300);
        check("full_latency", done_cyc, 32'd100);
        check("full_count", n_xfer, 32'd99);
        check("full_ndone", n_done, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        observe();
        check("done_width", {31'b0, done_out}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);

        // Random backpressure
        n_done = 0;
        observe(); drive(1'b0, 1'b1, 1'b1, 1'b1);
        run_until_done(1'b1, 2000);
        check("bp_count", n_xfer, 32'd99);
        check("bp_ndone", n_done, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);

        // Blanks and an invalid nibble at (4,4)
        board_in = '0; board_in[323 - 4*40 -: 4] = 4'hA; n_done = 0;
        observe(); drive(1'b1, 1'b1, 1'b1, 1'b1);
        run_until_done(1'b0, 300);
        check("blank_count", n_xfer, 32'd99);
        drive(1'b1, 1'b0, 1'b1, 1'b0);

        // Snapshot isolation and start while busy
        board_in = solved; n_done = 0;
        observe(); drive(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            observe();
            if (n_xfer == 20) begin
                board_in = {81{4'h9}};
                drive(1'b1, 1'b1, 1'b1, 1'b0);
            end else begin
                drive(1'b1, 1'b0, 1'b1, 1'b0);
            end
        end
        run_until_done(1'b0, 300);
        check("iso_count", n_xfer, 32'd99);
        check("iso_ndone", n_done, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        observe();
        check("iso_no_restart", {31'b0, valid_out}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);

        // Reset mid-stream
        board_in = solved; n_done = 0;
        observe(); drive(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 200 && n_xfer < 50; i++) begin
            observe(); drive(1'b1, 1'b0, 1'b1, 1'b0);
        end
        observe(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        sb.delete();
        observe();
        check("mid_rst_valid", {31'b0, valid_out}, 32'd0);
        check("mid_rst_busy", {31'b0, busy_out}, 32'd0);
        check("mid_rst_done", {31'b0, done_out}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        observe();
        check("mid_rst_ndone", n_done, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        run_until_done(1'b0, 300);
        check("post_rst_count", n_xfer, 32'd99);
        check("post_rst_latency", done_cyc, 32'd100);

        // Back-to-back: restart in the done cycle
        n_done = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        observe(); drive(1'b1, 1'b1, 1'b1, 1'b1);
        run_until_done(1'b0, 300);
        total = n_xfer;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        observe();
        check("b2b_valid", {31'b0, valid_out}, 32'd1);
        check("b2b_first", {24'b0, data_out}, 32'h35);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        run_until_done(1'b0, 300);
        total += n_xfer;
        check("b2b_total", total, 32'd198);
        check("b2b_ndone", n_done, 32'd2);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        observe(); drive(1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
